// File: rtl/sram_rw0_initiator_if.sv
//------------------------------------------------------------------------------
// sram_rw0_initiator_if : request/response channel of the RW0 SRAM initiator.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface sram_rw0_initiator_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int MASK_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [MASK_W-1:0] req_wmask;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_write;
   logic [DATA_W-1:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
      output req_ready, resp_valid, resp_write, resp_rdata
   );
endinterface

`default_nettype wire

// File: rtl/sram_rw0_initiator.sv
//------------------------------------------------------------------------------
// sram_rw0_initiator : RW0 single-port SRAM initiator with in-order response
// FIFO. Optional power-on array clear under macro SRAM_INIT_CLEAR_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sram_rw0_initiator #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int MASK_W     = 4,
   parameter int RESP_DEPTH = 3
) (
   input  wire                clock,
   input  wire                reset_n,
   sram_rw0_initiator_if.slave bus,
   output logic               init_busy,
   output logic               RW0_clk,
   output logic               RW0_en,
   output logic               RW0_wmode,
   output logic [ADDR_W-1:0]  RW0_addr,
   output logic [MASK_W-1:0]  RW0_wmask,
   output logic [DATA_W-1:0]  RW0_wdata,
   input  wire  [DATA_W-1:0]  RW0_rdata
);

   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(RESP_DEPTH);
   localparam logic [PTR_W-1:0] c_LAST    = PTR_W'(RESP_DEPTH - 1);
   localparam logic [CNT_W:0]   c_DEPTH_X = (CNT_W+1)'(RESP_DEPTH);

   logic              r_inflight_v;
   logic              r_inflight_w;
   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic              r_mem_w [RESP_DEPTH];
   logic [DATA_W-1:0] r_mem_d [RESP_DEPTH];

   logic              w_busy;
   logic              w_clr_drv;
   logic [ADDR_W-1:0] w_clr_addr;
   logic [CNT_W:0]    w_occ;
   logic              w_fire;
   logic              w_push;
   logic              w_pop;

`ifdef SRAM_INIT_CLEAR_EN
   localparam logic [0:0] c_ST_CLEAR = 1'b0;
   localparam logic [0:0] c_ST_RUN   = 1'b1;

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_clr_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_ST_CLEAR;
         r_clr_cnt <= '0;
      end else if (r_state == c_ST_CLEAR) begin
         r_clr_cnt <= r_clr_cnt + 1'b1;
         if (r_clr_cnt == '1)
            r_state <= c_ST_RUN;
      end
   end

   assign w_busy     = (r_state == c_ST_CLEAR);
   assign w_clr_addr = r_clr_cnt;
`else
   assign w_busy     = 1'b0;
   assign w_clr_addr = '0;
`endif

   // Array drive is gated by reset_n so nothing reaches the array while held in reset.
   assign w_clr_drv = w_busy & reset_n;
   assign init_busy = w_busy;

   assign w_occ         = {1'b0, r_count} + (CNT_W+1)'(r_inflight_v);
   assign bus.req_ready = reset_n & ~w_busy & (w_occ < c_DEPTH_X);
   assign w_fire        = bus.req_valid & bus.req_ready;
   assign w_push        = r_inflight_v;
   assign w_pop         = bus.resp_valid & bus.resp_ready;

   assign RW0_clk   = clock;
   assign RW0_en    = w_fire | w_clr_drv;
   assign RW0_wmode = (w_fire & bus.req_write) | w_clr_drv;
   assign RW0_addr  = w_clr_drv ? w_clr_addr : bus.req_addr;
   assign RW0_wmask = w_clr_drv ? {MASK_W{1'b1}} : bus.req_wmask;
   assign RW0_wdata = w_clr_drv ? {DATA_W{1'b0}} : bus.req_wdata;

   assign bus.resp_valid = (r_count != '0);
   assign bus.resp_write = bus.resp_valid & r_mem_w[r_rd_ptr];
   assign bus.resp_rdata = bus.resp_valid ? r_mem_d[r_rd_ptr] : {DATA_W{1'b0}};

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == c_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_inflight_v <= 1'b0;
         r_inflight_w <= 1'b0;
      end else begin
         r_inflight_v <= w_fire;
         r_inflight_w <= bus.req_write;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_pop)
            r_rd_ptr <= f_inc(r_rd_ptr);
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem_w[r_wr_ptr] <= r_inflight_w;
         r_mem_d[r_wr_ptr] <= r_inflight_w ? {DATA_W{1'b0}} : RW0_rdata;
      end
   end

   a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
      !(w_push && !w_pop && (r_count == c_DEPTH)));

endmodule

`default_nettype wire

// File: tb/tb_sram_rw0_initiator.sv
//------------------------------------------------------------------------------
// tb_sram_rw0_initiator : directed scoreboard bench with a behavioural RW0 array.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sram_rw0_initiator;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;
   localparam int DEPTH  = 3;
   localparam int WORDS  = 2**ADDR_W;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   sram_rw0_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus();

   logic              init_busy, RW0_clk, RW0_en, RW0_wmode;
   logic [ADDR_W-1:0] RW0_addr;
   logic [MASK_W-1:0] RW0_wmask;
   logic [DATA_W-1:0] RW0_wdata;
   logic [DATA_W-1:0] RW0_rdata;

   sram_rw0_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
                        .RESP_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus), .init_busy(init_busy),
      .RW0_clk(RW0_clk), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
      .RW0_addr(RW0_addr), .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata),
      .RW0_rdata(RW0_rdata)
   );

   // Behavioural array driven by the DUT; ref_mem is the bench's own expectation.
   logic [DATA_W-1:0] arr     [WORDS];
   logic [DATA_W-1:0] ref_mem [WORDS];

   always @(posedge RW0_clk) begin
      if (RW0_en) begin
         if (RW0_wmode) begin
            for (int l = 0; l < MASK_W; l++)
               if (RW0_wmask[l]) arr[RW0_addr][l*8 +: 8] <= RW0_wdata[l*8 +: 8];
         end else begin
            RW0_rdata <= arr[RW0_addr];
         end
      end
   end

   typedef struct {
      logic              w;
      logic [DATA_W-1:0] d;
      int                cyc;
      bit                lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   bit   lat_en   = 1'b0;

   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   exp_t m_e;
   always @(negedge clock) begin
      if (reset_n && bus.resp_valid && bus.resp_ready) begin
         if (sb.size() == 0) begin
            check("stale_resp", bus.resp_valid, 1'b0);
         end else begin
            m_e = sb.pop_front();
            check("resp_write", bus.resp_write, m_e.w);
            check("resp_rdata", bus.resp_rdata, m_e.d);
            if (m_e.lat) check("resp_latency", cyc - m_e.cyc, 2);
         end
      end
   end

   function automatic logic [DATA_W-1:0] pat(input int i);
      return 32'h5A000000 | i;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the fire edge.
   task automatic send(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m,
                       output int waits);
      exp_t e;
      bit   done;
      done  = 1'b0;
      waits = 0;
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
      bus.req_wdata = d;    bus.req_wmask = m;
      while (!done && waits < 64) begin
         @(negedge clock);
         if (bus.req_ready) begin
            check("issue_en", RW0_en, 1'b1);
            check("issue_wmode", RW0_wmode, w);
            check("issue_addr", RW0_addr, a);
            if (w)
               for (int l = 0; l < MASK_W; l++)
                  if (m[l]) ref_mem[a][l*8 +: 8] = d[l*8 +: 8];
            e.w = w; e.d = w ? '0 : ref_mem[a]; e.cyc = cyc; e.lat = lat_en;
            sb.push_back(e);
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clock); #1;
      end
      if (!done) check("req_timeout", bus.req_ready, 1'b1);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("drain", sb.size(), 0);
      @(posedge clock); #1;
   endtask

   // Entered right after the reset-release negedge.
   task automatic wait_init();
      #1;
`ifdef SRAM_INIT_CLEAR_EN
      begin
         int busy, bad;
         busy = 0; bad = 0;
         while (init_busy && busy < 5000) begin
            if (bus.req_ready) bad++;
            busy++;
            @(negedge clock); #1;
         end
         check("init_cycles", busy, WORDS);
         check("init_ready_low", bad, 0);
         for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
      end
`else
      check("init_busy_off", init_busy, 1'b0);
`endif
      check("ready_after_reset", bus.req_ready, 1'b1);
      @(posedge clock); #1;
   endtask

   initial begin
      int w, tot, acc;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0;   bus.req_wmask = '0;   bus.resp_ready = 1'b1;
      for (int i = 0; i < WORDS; i++) begin
         arr[i] = pat(i);
         ref_mem[i] = pat(i);
      end

      // Reset state, with a request pending to prove the array is not enabled.
      bus.req_valid = 1'b1; bus.req_write = 1'b1;
      repeat (2) @(posedge clock); #1;
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_resp_write", bus.resp_write, 1'b0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
      check("rst_en", RW0_en, 1'b0);
      check("rst_wmode", RW0_wmode, 1'b0);
`ifdef SRAM_INIT_CLEAR_EN
      check("rst_init_busy", init_busy, 1'b1);
`else
      check("rst_init_busy", init_busy, 1'b0);
`endif
      bus.req_valid = 1'b0; bus.req_write = 1'b0;
      @(negedge clock); reset_n = 1'b1;
      wait_init();

      // Full write then read-back with latency checking.
      lat_en = 1'b1;
      send(1'b1, 12'h005, 32'hDEADBEEF, 4'hF, w);
      send(1'b0, 12'h005, '0, '0, w);
      @(negedge clock);
      check("idle_en", RW0_en, 1'b0);
      check("idle_wmode", RW0_wmode, 1'b0);
      @(posedge clock); #1;
      wait_drain();

      // Lane-masked write and zero-mask write.
      send(1'b1, 12'h005, 32'h11223344, 4'h2, w);
      send(1'b0, 12'h005, '0, '0, w);
      send(1'b1, 12'h006, 32'hFFFFFFFF, 4'h0, w);
      send(1'b0, 12'h006, '0, '0, w);
      wait_drain();

      // Back-to-back reads must never stall.
      tot = 0;
      for (int i = 0; i < 16; i++) begin
         send(1'b0, ADDR_W'(i), '0, '0, w);
         tot += w;
      end
      check("b2b_stalls", tot, 0);
      wait_drain();
      lat_en = 1'b0;

      // Backpressure: exactly DEPTH requests accepted.
      bus.resp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 12'h020;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (bus.req_ready) begin
            m_e.w = 1'b0; m_e.d = ref_mem[bus.req_addr]; m_e.cyc = cyc; m_e.lat = 1'b0;
            sb.push_back(m_e);
            acc++;
         end
         @(posedge clock); #1;
         bus.req_addr = ADDR_W'(12'h020 + acc);
      end
      bus.req_valid = 1'b0;
      check("bp_accepted", acc, DEPTH);
      check("bp_ready_low", bus.req_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("bp_hold_valid", bus.resp_valid, 1'b1);
         check("bp_hold_rdata", bus.resp_rdata, sb[0].d);
      end
      @(posedge clock); #1;
      bus.resp_ready = 1'b1;
      wait_drain();
      check("bp_ready_back", bus.req_ready, 1'b1);

      // Reset with two queued responses and one inflight.
      bus.resp_ready = 1'b0;
      send(1'b0, 12'h030, '0, '0, w);
      send(1'b0, 12'h031, '0, '0, w);
      send(1'b0, 12'h032, '0, '0, w);
      bus.req_valid = 1'b1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", bus.resp_valid, 1'b0);
      check("mid_rst_en", RW0_en, 1'b0);
      sb.delete();
      bus.req_valid = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock); reset_n = 1'b1;
      wait_init();
      bus.resp_ready = 1'b1;
      tot = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         if (bus.resp_valid) tot++;
      end
      check("no_stale_after_rst", tot, 0);
      @(posedge clock); #1;

      // Top address read.
      send(1'b0, 12'hFFF, '0, '0, w);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/sram_rw0_initiator.md
Name: sram_rw0_initiator

Overview:
- Initiator side of the RW0 single-port SRAM interface used by the cache data/tag array wrappers.
- Accepts read/write requests on a valid/ready channel and drives RW0_en/RW0_wmode/RW0_addr/RW0_wmask/RW0_wdata.
- Captures RW0_rdata one cycle after issue and returns in-order responses through a small response FIFO with backpressure.
- Sits between a bus slave (scratchpad/boot RAM port) and any *_ext array wrapper.

Parameters:
- ADDR_W, 12, RW0 address width (word address).
- DATA_W, 32, data width.
- MASK_W, 4, write-mask width (one bit per DATA_W/MASK_W lane).
- RESP_DEPTH, 3, response FIFO entries; minimum 2.

Ports:
- clock  in  1  sole clock; also drives RW0_clk.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready (fire).
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_wmask  in  MASK_W  write lane mask.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed when resp_valid & resp_ready.
- resp_write  out  1  response belongs to a write.
- resp_rdata  out  DATA_W  read data; 0 for write responses.
- init_busy  out  1  clear engine active (see Optional Feature).
- RW0_clk  out  1  = clock.
- RW0_en  out  1  array enable.
- RW0_wmode  out  1  write mode.
- RW0_addr  out  ADDR_W  array address.
- RW0_wmask  out  MASK_W  array write mask.
- RW0_wdata  out  DATA_W  array write data.
- RW0_rdata  in  DATA_W  array read data, valid the cycle after an enabled read.

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream): FIFO empty, inflight=0, resp_valid=0, resp_write=0, resp_rdata=0, RW0_en=0, RW0_wmode=0, init_busy=0 (macro off) or 1 (macro on).
- Issue: in the fire cycle N, RW0_en=1, RW0_wmode=req_write, RW0_addr/wmask/wdata=req_* (combinational pass-through). Outside fire, RW0_en=0 and RW0_wmode=0; addr/wdata/wmask follow req_* (don't-care to the array).
- Inflight stage: register inflight_v<=fire and inflight_w<=req_write at edge N. In cycle N+1, RW0_rdata is sampled. At edge N+1 push {inflight_w, inflight_w ? 0 : RW0_rdata} into the FIFO.
- Response: resp_valid=1 from cycle N+2; read-to-response latency 2 cycles. Responses are strictly in request order. Outputs are driven from the FIFO head and stay stable while resp_valid & !resp_ready.
- Flow control: req_ready = !init_busy & ((count + inflight_v) < RESP_DEPTH). Derived from registers only, with no combinational path from resp_ready or req_valid. With RESP_DEPTH=3 and resp_ready held at 1, one request per cycle is sustained.
- Simultaneous push and pop in one cycle: count is unchanged, and the head advances to the next entry or to the bypassed pushed entry.
- Pop on an empty FIFO is impossible (resp_valid=0). Push into a full FIFO cannot happen given the req_ready rule; assertion-checked.
- Writes with req_wmask=0 are still issued (RW0_en=1) and still produce a response.
- Reset mid-operation: inflight request and all queued responses are discarded and no response is produced. An array write issued in the reset cycle may or may not complete.
- Pointer wrap: read/write pointers wrap modulo RESP_DEPTH (non-power-of-2 supported). count is ceil(log2(RESP_DEPTH+1)) bits.

Optional Feature:
- Macro SRAM_INIT_CLEAR_EN.
- Defined: a two-state FSM CLEAR -> RUN.
  - CLEAR is entered on reset. Each cycle it drives RW0_en=1, RW0_wmode=1, RW0_wmask=all ones, RW0_wdata=0 and RW0_addr=clr_cnt, with clr_cnt going 0..2^ADDR_W-1. No responses are generated.
  - After address 2^ADDR_W-1 is written, the FSM moves to RUN the following cycle. init_busy=1 during CLEAR, req_ready=0.
  - Duration: exactly 2^ADDR_W cycles after reset release; 4096 cycles with defaults.
- Undefined: no FSM or counter; init_busy tied 0; the block enters normal operation the first cycle after reset release.

Test Plan:
- Write addr 0x005, wdata 0xDEADBEEF, wmask 0xF, then read 0x005 with resp_ready=1 -> RW0_en pulses 1 cycle each; write response resp_write=1, rdata=0; read response resp_rdata=0xDEADBEEF two cycles after read fire.
- Byte-mask write of 0x11223344 with wmask 0x2 over 0xDEADBEEF, then read -> 0xDEAD33EF.
- Back-to-back reads of 0x000..0x00F with resp_ready=1 -> req_ready stays 1, 16 responses on 16 consecutive cycles, in order.
- resp_ready=0 while issuing reads -> exactly 3 requests accepted, then req_ready=0. Release resp_ready -> responses drain in order and req_ready reasserts.
- Assert reset_n=0 with 2 queued responses and 1 inflight -> resp_valid=0 and RW0_en=0 immediately; no stale response after release.
- With SRAM_INIT_CLEAR_EN, preload a nonzero array then reset -> init_busy=1 and req_ready=0 for 4096 cycles; a subsequent read of 0xFFF returns 0x00000000.
